// File: rtl/led_counter_pkg.sv
// ---------------------------------------------------------------------------
// led_counter_pkg
// Shared definitions for the LED counter control slice:
//   - state_e        : controller FSM encoding (IDLE/RUN/PAUSE, 2'b11 unused)
//   - *_DEFAULT      : board-level defaults for tick period and debounce time
//   - C_SPEED_SHIFT  : shift applied per speed-select step
//   - tick_period()  : tick period for a given speed select, never below 1
// ---------------------------------------------------------------------------
package led_counter_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10
  } state_e;

  localparam int unsigned C_MAX_COUNT_DEFAULT = 100_000_000;  // 1 s at 100 MHz
  localparam int unsigned C_DEBOUNCE_DEFAULT  = 1_000_000;    // 10 ms at 100 MHz
  localparam int unsigned C_SPEED_SHIFT       = 2;

  // Each speed step divides the base period by 4; a period of 0 would
  // never fire, so it is clamped to 1 (a tick every cycle).
  function automatic int unsigned tick_period(input int unsigned max_count,
                                              input logic [1:0]  speed);
    int unsigned p;
    p = max_count >> (C_SPEED_SHIFT * int'(speed));
    return (p == 0) ? 1 : p;
  endfunction

endpackage

// File: rtl/led_counter_ctrl_btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Cleans one raw push-button: 2-FF synchroniser, stability counter and a
// rising-edge detector on the debounced level.
//   clk     : system clock
//   rst     : asynchronous active-high reset
//   btn_i   : raw button level
//   press_o : one-cycle pulse when the debounced level rises
// Latency from raw press to press_o is 2 + C_DEBOUNCE + 1 cycles (the pulse
// is consumed on that edge). Releases produce no pulse.
// ---------------------------------------------------------------------------
module btn_debounce
  import led_counter_pkg::*;
#(
  parameter int unsigned C_DEBOUNCE = C_DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CW = $clog2(C_DEBOUNCE + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          level_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronised input disagrees with the
  // accepted level; any return to agreement restarts it from zero.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(C_DEBOUNCE - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn_i;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      cnt_q        <= cnt_d;
    end
  end

  assign press_o = level_q & ~level_prev_q;

endmodule

// File: rtl/led_counter_ctrl.sv
// ---------------------------------------------------------------------------
// led_counter_ctrl
// Run/pause/step/direction/clear controller for the 16-bit LED counter.
//   clk     : 100 MHz system clock
//   btnC    : asynchronous active-high reset
//   btnU    : run/pause toggle (raw)
//   btnD    : single step (raw)
//   btnL    : direction toggle (raw)
//   btnR    : clear (raw)
//   sw      : speed select, tick period = C_MAX_COUNT >> (2*sw), min 1
//   cnt_en  : one-cycle count-enable strobe
//   cnt_up  : count direction, 1 = increment
//   cnt_clr : one-cycle synchronous clear strobe
//   state   : FSM state for status LEDs
// All outputs are registered: they follow the press pulse or terminal
// count that causes them by one cycle.
// ---------------------------------------------------------------------------
module led_counter_ctrl
  import led_counter_pkg::*;
#(
  parameter int unsigned C_MAX_COUNT = C_MAX_COUNT_DEFAULT,
  parameter int unsigned C_DEBOUNCE  = C_DEBOUNCE_DEFAULT
) (
  input  logic       clk,
  input  logic       btnC,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       btnL,
  input  logic       btnR,
  input  logic [1:0] sw,
  output logic       cnt_en,
  output logic       cnt_up,
  output logic       cnt_clr,
  output logic [1:0] state
);

  localparam int unsigned PW = $clog2(C_MAX_COUNT + 1);

  // Button order in the vector: [0]=U, [1]=D, [2]=L, [3]=R
  logic [3:0] btn_raw;
  logic [3:0] press;

  assign btn_raw = {btnR, btnL, btnD, btnU};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
      btn_debounce #(
        .C_DEBOUNCE(C_DEBOUNCE)
      ) u_debounce (
        .clk    (clk),
        .rst    (btnC),
        .btn_i  (btn_raw[gi]),
        .press_o(press[gi])
      );
    end
  endgenerate

  logic press_u, press_d, press_l, press_r;
  assign press_u = press[0];
  assign press_d = press[1];
  assign press_l = press[2];
  assign press_r = press[3];

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [PW-1:0] period;
  logic [1:0]    sw_q;
  logic          sw_chg;
  logic          tc;
  logic          cnt_en_q, cnt_en_d;
  logic          cnt_clr_q, cnt_clr_d;
  logic          cnt_up_q, cnt_up_d;

  assign period = PW'(tick_period(C_MAX_COUNT, sw));
  assign sw_chg = (sw != sw_q);
  assign tc     = (presc_q == period - PW'(1));

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    cnt_en_d  = 1'b0;
    cnt_clr_d = 1'b0;
    // Direction is independent of every other button and of the state.
    cnt_up_d  = cnt_up_q ^ press_l;

    case (state_q)
      S_IDLE, S_PAUSE: begin
        if (press_u) begin
          state_d = S_RUN;
          presc_d = '0;
        end else if (press_d) begin
          cnt_en_d = 1'b1;
        end
      end
      S_RUN: begin
        // Step is meaningless while free-running, so D is ignored here.
        if (press_u) begin
          state_d = S_PAUSE;
        end else if (sw_chg) begin
          // Restart the period cleanly so a speed change never yields a
          // truncated first tick.
          presc_d = '0;
        end else if (tc) begin
          cnt_en_d = 1'b1;
          presc_d  = '0;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (sw_chg) begin
      presc_d = '0;
    end

    // Clear overrides everything, including a pending enable.
    if (press_r) begin
      state_d   = S_IDLE;
      presc_d   = '0;
      cnt_en_d  = 1'b0;
      cnt_clr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge btnC) begin
    if (btnC) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      sw_q      <= 2'b00;
      cnt_en_q  <= 1'b0;
      cnt_clr_q <= 1'b0;
      cnt_up_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      sw_q      <= sw;
      cnt_en_q  <= cnt_en_d;
      cnt_clr_q <= cnt_clr_d;
      cnt_up_q  <= cnt_up_d;
    end
  end

  assign cnt_en  = cnt_en_q;
  assign cnt_clr = cnt_clr_q;
  assign cnt_up  = cnt_up_q;
  assign state   = state_q;

endmodule
